// File: rtl/key_onehot_debouncer.sv
// Four-key debouncer: synchronizes raw key lines, qualifies a stable press or
// release, and presents the pressed key as a registered one-hot code.
module key_onehot_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic       y3,
  output logic       y2,
  output logic       y1,
  output logic       y0,
  output logic       key_valid,
  output logic       multi_err
);

  localparam int unsigned KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_sync2;
  logic [KEY_W-1:0] w_sync;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [KEY_W-1:0] r_cand;
  logic [KEY_W-1:0] w_cand_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [KEY_W-1:0] r_y;
  logic [KEY_W-1:0] w_y_nxt;
  logic             r_key_valid;
  logic             w_key_valid_nxt;
  logic             r_multi_err;
  logic             w_multi_err_nxt;
  logic             w_cand_onehot;

  // Two-flop synchronizer; nothing else looks at key_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync        = r_sync2;
  assign w_cand_onehot = (r_cand != '0) && ((r_cand & (r_cand - KEY_W'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_y         <= '0;
      r_key_valid <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_y         <= w_y_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_multi_err <= w_multi_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_cnt_nxt       = r_cnt;
    w_y_nxt         = r_y;
    w_key_valid_nxt = 1'b0;
    w_multi_err_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        w_y_nxt = '0;
        if (w_sync != '0) begin
          w_cand_nxt  = w_sync;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        w_y_nxt = '0;
        if (w_sync == '0) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_sync != r_cand) begin
          w_cand_nxt = w_sync;
          w_cnt_nxt  = CNT_ONE;
        end else if (r_cnt == CNT_LAST) begin
          // Multi-key chords are rejected and must be fully released first.
          if (w_cand_onehot) begin
            w_y_nxt         = r_cand;
            w_key_valid_nxt = 1'b1;
            w_state_nxt     = PRESSED;
          end else begin
            w_multi_err_nxt = 1'b1;
            w_cnt_nxt       = CNT_ONE;
            w_state_nxt     = RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      PRESSED: begin
        if (w_sync != r_cand) begin
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = RELEASE;
        end
      end

      RELEASE: begin
        if (w_sync != '0) begin
          w_cnt_nxt = CNT_ONE;
        end else if (r_cnt == CNT_LAST) begin
          w_y_nxt     = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_y_nxt     = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign y3        = r_y[3];
  assign y2        = r_y[2];
  assign y1        = r_y[1];
  assign y0        = r_y[0];
  assign key_valid = r_key_valid;
  assign multi_err = r_multi_err;

endmodule

// File: tb/tb_key_onehot_debouncer.sv
// Bench for key_onehot_debouncer: default (4) and 1-cycle debounce instances
// driven in lockstep and compared every edge against a run-length reference model.
module tb_key_onehot_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] ya, yb;
  logic       kva, kvb, mea, meb;

  always #5 clk = ~clk;

  key_onehot_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .y3(ya[3]), .y2(ya[2]), .y1(ya[1]), .y0(ya[0]),
    .key_valid(kva), .multi_err(mea)
  );

  key_onehot_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .y3(yb[3]), .y2(yb[2]), .y1(yb[1]), .y0(yb[0]),
    .key_valid(kvb), .multi_err(meb)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: mode 0 = waiting for a stable press, 1 = showing a key,
  // 2 = waiting for a stable all-released input.
  int         dc[2] = '{4, 1};
  int         md[2];
  int         run[2];
  int         zc[2];
  logic [3:0] s1[2], s2[2], last[2], held[2];
  logic       ekv[2], eme[2];

  int tcnt;
  int fk[2], fz[2], nkv[2], nme[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    logic [3:0] s;
    s      = s2[i];
    ekv[i] = 1'b0;
    eme[i] = 1'b0;
    if (!rst_n) begin
      md[i] = 0; run[i] = 0; zc[i] = 0;
      s1[i] = '0; s2[i] = '0; last[i] = '0; held[i] = '0;
    end else begin
      case (md[i])
        0: begin
          if (s == 4'b0000) begin
            run[i] = 0;
          end else begin
            if (run[i] > 0 && s == last[i]) run[i]++;
            else run[i] = 1;
            last[i] = s;
            if (run[i] == dc[i] + 1) begin
              if ($countones(s) == 1) begin
                held[i] = s; ekv[i] = 1'b1; md[i] = 1;
              end else begin
                eme[i] = 1'b1; md[i] = 2; zc[i] = 1;
              end
            end
          end
        end
        1: if (s != held[i]) begin md[i] = 2; zc[i] = 1; end
        default: begin
          if (s != 4'b0000) zc[i] = 1;
          else if (zc[i] == dc[i]) begin held[i] = '0; md[i] = 0; run[i] = 0; end
          else zc[i]++;
        end
      endcase
      s2[i] = s1[i];
      s1[i] = key_in;
    end
  endtask

  task automatic compare_all();
    logic [3:0] y;
    logic       kv, me;
    for (int i = 0; i < 2; i++) begin
      y  = (i == 0) ? ya  : yb;
      kv = (i == 0) ? kva : kvb;
      me = (i == 0) ? mea : meb;
      chk($sformatf("y_i%0d", i), 32'(y), 32'(held[i]));
      chk($sformatf("key_valid_i%0d", i), 32'(kv), 32'(ekv[i]));
      chk($sformatf("multi_err_i%0d", i), 32'(me), 32'(eme[i]));
      chk($sformatf("onehot_i%0d", i), 32'($countones(y) <= 1), 32'd1);
      chk($sformatf("excl_i%0d", i), 32'(kv & me), 32'd0);
      if (kv) nkv[i]++;
      if (me) nme[i]++;
      if (kv && fk[i] == 0) fk[i] = tcnt;
      if (y == 4'b0000 && fz[i] == 0) fz[i] = tcnt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    tcnt++;
    compare_all();
  endtask

  task automatic start_meas();
    tcnt = 0;
    fk = '{0, 0}; fz = '{0, 0}; nkv = '{0, 0}; nme = '{0, 0};
  endtask

  task automatic async_reset_check();
    rst_n = 1'b0;
    #1;
    model_step(0);
    model_step(1);
    compare_all();
    chk("async_rst_y", 32'({ya, yb, kva, kvb, mea, meb}), 32'd0);
  endtask

  task automatic hold_key(input logic [3:0] k, input int n);
    key_in = k;
    repeat (n) tick();
  endtask

  initial begin
    logic [3:0] k;
    rst_n  = 1'b1;
    key_in = 4'b0000;
    start_meas();
    #1;
    async_reset_check();
    repeat (3) tick();
    rst_n = 1'b1;

    // Clean press and release of key 2
    key_in = 4'b0100;
    start_meas();
    repeat (12) tick();
    chk("press_lat_d4", 32'(fk[0]), 32'd7);
    chk("press_lat_d1", 32'(fk[1]), 32'd4);
    chk("press_pulses", 32'(nkv[0]), 32'd1);
    chk("press_y2", 32'(ya), 32'b0100);
    key_in = 4'b0000;
    start_meas();
    repeat (10) tick();
    chk("rel_lat_d4", 32'(fz[0]), 32'd7);
    chk("rel_lat_d1", 32'(fz[1]), 32'd4);
    chk("rel_pulses", 32'(nkv[0] + nme[0]), 32'd0);

    // Bouncing key 0, then stable
    start_meas();
    for (int c = 0; c < 10; c++) begin
      key_in = ((c / 2) % 2 == 1) ? 4'b0001 : 4'b0000;
      tick();
    end
    chk("bounce_quiet", 32'(nkv[0] + nme[0]), 32'd0);
    key_in = 4'b0001;
    start_meas();
    repeat (12) tick();
    chk("bounce_lat", 32'(fk[0]), 32'd7);
    chk("bounce_pulses", 32'(nkv[0]), 32'd1);
    chk("bounce_y0", 32'(ya), 32'b0001);
    hold_key(4'b0000, 10);

    // Two keys at once
    key_in = 4'b1010;
    start_meas();
    repeat (10) tick();
    chk("multi_err_cnt", 32'(nme[0]), 32'd1);
    chk("multi_no_valid", 32'(nkv[0]), 32'd0);
    chk("multi_y_zero", 32'(ya), 32'd0);
    hold_key(4'b0000, 7);

    // Candidate changes mid-debounce
    hold_key(4'b1000, 3);
    key_in = 4'b0010;
    start_meas();
    repeat (12) tick();
    chk("restart_lat", 32'(fk[0]), 32'd7);
    chk("restart_y1", 32'(ya), 32'b0010);
    hold_key(4'b0000, 10);

    // Reset while pressed, key still held afterwards
    hold_key(4'b1000, 10);
    chk("pre_rst_y3", 32'(ya), 32'b1000);
    async_reset_check();
    repeat (2) tick();
    rst_n = 1'b1;
    start_meas();
    repeat (12) tick();
    chk("post_rst_lat_d4", 32'(fk[0]), 32'd7);
    chk("post_rst_lat_d1", 32'(fk[1]), 32'd4);
    chk("post_rst_y3", 32'(ya), 32'b1000);
    hold_key(4'b0000, 10);

    // Short debounce instance, key 1
    key_in = 4'b0010;
    start_meas();
    repeat (8) tick();
    chk("d1_lat", 32'(fk[1]), 32'd4);
    chk("d1_y1", 32'(yb), 32'b0010);
    hold_key(4'b0000, 10);

    // Randomized key activity with occasional resets
    for (int n = 0; n < 90; n++) begin
      case ($urandom_range(0, 3))
        0:       k = 4'b0000;
        1, 2:    k = 4'(1 << $urandom_range(0, 3));
        default: k = 4'($urandom_range(1, 15));
      endcase
      if ($urandom_range(0, 19) == 0) begin
        async_reset_check();
        tick();
        rst_n = 1'b1;
      end
      hold_key(k, $urandom_range(1, 14));
    end
    hold_key(4'b0000, 10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
